// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into HIGH_CYCLES-long high windows, each followed by a GAP_CYCLES low gap.
// Pulses that arrive during a window are queued in a saturating counter. Define PULSE_STRETCHER_OVERFLOW_EN to add a sticky overflow flag.
module pulse_stretcher #(
   parameter int HIGH_CYCLES = 10_000_000,
   parameter int GAP_CYCLES  = 5_000_000,
   parameter int PEND_BITS   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 input_pulse,
   output logic                 output_stretched,
   output logic                 busy,
   output logic [PEND_BITS-1:0] pending
`ifdef PULSE_STRETCHER_OVERFLOW_EN
   ,
   output logic                 overflow
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam int MAX_C = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0]     HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [PEND_BITS-1:0] P_ONE     = PEND_BITS'(1);
   localparam logic [PEND_BITS-1:0] P_FULL    = '1;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PEND_BITS-1:0] p_q, p_d;
   logic                 out_q, out_d;
   logic                 busy_q, busy_d;
   logic                 drop;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      drop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (input_pulse) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end
         end
         S_HIGH: begin
            if (cnt_q == HIGH_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
            if (input_pulse) begin
               if (p_q == P_FULL) drop = 1'b1;
               else               p_d  = p_q + P_ONE;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               // A pulse arriving with the dequeue cancels it: P is unchanged and the pulse is never dropped
               if (p_q != '0 || input_pulse) begin
                  state_d = S_HIGH;
                  if (!input_pulse) p_d = p_q - P_ONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (input_pulse) begin
                  if (p_q == P_FULL) drop = 1'b1;
                  else               p_d  = p_q + P_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Outputs are registered from the next state so that they line up with it
      out_d  = (state_d == S_HIGH);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign output_stretched = out_q;
   assign busy             = busy_q;
   assign pending          = p_q;

`ifdef PULSE_STRETCHER_OVERFLOW_EN
   logic overflow_q, overflow_d;

   always_comb overflow_d = overflow_q | drop;

   always_ff @(posedge clk) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HIGH_CYCLES=4, GAP_CYCLES=2 and PEND_BITS=2.
// Each scenario runs 36 cycles; reset is held in cycles 0-3 and outputs are checked cycle by cycle.
module tb_pulse_stretcher;
   localparam int H = 4, G = 2, PB = 2, NC = 36;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic input_pulse = 1'b0;
   logic output_stretched, busy;
   logic [PB-1:0] pending;
`ifdef PULSE_STRETCHER_OVERFLOW_EN
   logic overflow;
   logic [NC-1:0] vm;
`endif

   int checks = 0;
   int errors = 0;

   // Per-scenario stimulus and expected masks, where bit c refers to cycle c
   logic [NC-1:0] pm, rm, om, bm;
   logic [NC-1:0][PB-1:0] pd;

   always #5 clk = ~clk;

   pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_BITS(PB)) dut (
      .clk              (clk),
      .reset            (reset),
      .input_pulse      (input_pulse),
      .output_stretched (output_stretched),
      .busy             (busy),
      .pending          (pending)
`ifdef PULSE_STRETCHER_OVERFLOW_EN
      ,
      .overflow         (overflow)
`endif
   );

   function automatic logic [NC-1:0] rng(input int lo, input int hi);
      logic [NC-1:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic setp(input int lo, input int hi, input int v);
      for (int i = lo; i <= hi; i++) pd[i] = PB'(v);
   endtask

   task automatic clear_exp();
      pm = '0;
      rm = rng(0, 3);
      om = '0;
      bm = '0;
      pd = '0;
`ifdef PULSE_STRETCHER_OVERFLOW_EN
      vm = '0;
`endif
   endtask

   task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0d expected %0d", tag, c, obs, exp);
      end
   endtask

   // Inputs for cycle c are set just after the edge that starts it; outputs are sampled on the falling edge
   task automatic run(input string name);
      for (int c = 0; c < NC; c++) begin
         input_pulse = pm[c];
         reset       = rm[c];
         @(negedge clk);
         if (c > 0) begin
            chk({name, ".out"},  c, {7'd0, output_stretched}, {7'd0, om[c]});
            chk({name, ".busy"}, c, {7'd0, busy},             {7'd0, bm[c]});
            chk({name, ".pend"}, c, {6'd0, pending},          {6'd0, pd[c]});
`ifdef PULSE_STRETCHER_OVERFLOW_EN
            chk({name, ".ovf"},  c, {7'd0, overflow},         {7'd0, vm[c]});
`endif
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      @(posedge clk);
      #1;

      // A single pulse gives one window followed by one gap
      clear_exp();
      pm = rng(10, 10);
      om = rng(11, 14);
      bm = rng(11, 16);
      run("single");

      // Pulses that arrive during a window are queued and replayed
      clear_exp();
      pm = rng(10, 10) | rng(12, 13);
      om = rng(11, 14) | rng(17, 20) | rng(23, 26);
      bm = rng(11, 28);
      setp(13, 13, 1); setp(14, 16, 2); setp(17, 22, 1);
      run("queue");

      // Saturation: the pulse in cycle 14 arrives with P full and is dropped
      clear_exp();
      pm = rng(10, 14);
      om = rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32);
      bm = rng(11, 34);
      setp(12, 12, 1); setp(13, 13, 2); setp(14, 16, 3);
      setp(17, 22, 2); setp(23, 28, 1);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
      vm = rng(15, 35);
`endif
      run("sat");

      // A pulse in the last gap cycle with P=0 starts the next window directly
      clear_exp();
      pm = rng(10, 10) | rng(16, 16);
      om = rng(11, 14) | rng(17, 20);
      bm = rng(11, 22);
      run("lastgap");

      // Reset in the middle of a window, together with a pulse
      clear_exp();
      pm = rng(10, 10) | rng(12, 13);
      rm = rng(0, 3) | rng(13, 13);
      om = rng(11, 13);
      bm = rng(11, 13);
      setp(13, 13, 1);
      run("midreset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guards against a stuck run
   initial begin
      #100000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses, such as the output of the push-button debouncer, into long, stable, human-visible high periods. Each accepted pulse yields exactly one high window of HIGH_CYCLES cycles followed by a mandatory low gap of GAP_CYCLES cycles. Pulses that arrive while a window or gap is in progress are queued in a saturating pending counter, so rapid presses are replayed rather than lost. The block sits between input conditioning and the LED, buzzer and display drivers on the BASYS3 top level.

## Interface
- HIGH_CYCLES, 10_000_000: length of each high window in clk cycles; must be ≥ 1.
- GAP_CYCLES, 5_000_000: length of each mandatory low gap in clk cycles; must be ≥ 1.
- PEND_BITS, 3: width of the pending counter; at most 2**PEND_BITS−1 pulses are held.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset; dominates all other inputs.
- input_pulse  input  1  event request, synchronous to clk; every cycle it is high counts as one pulse.
- output_stretched  output  1  registered stretched output.
- busy  output  1  registered; 1 when the state is not IDLE.
- pending  output  PEND_BITS  registered count of queued pulses.
- overflow  output  1  sticky flag for a dropped pulse; present only with PULSE_STRETCHER_OVERFLOW_EN.

## Operation
- Registers: state (IDLE, HIGH or GAP); cnt, width $clog2(max(HIGH_CYCLES, GAP_CYCLES)); P, width PEND_BITS; overflow.
- Reset: state=IDLE, cnt=0, P=0, output_stretched=0, busy=0, pending=0, overflow=0. A pulse sampled during reset is discarded.
- IDLE:
  - If input_pulse=1: go to HIGH with cnt=0. This pulse is consumed and does not change P.
  - Otherwise stay in IDLE.
- HIGH:
  - output_stretched=1.
  - cnt increments each cycle.
  - At cnt=HIGH_CYCLES−1: go to GAP with cnt=0.
- GAP:
  - output_stretched=0.
  - cnt increments each cycle.
  - At cnt=GAP_CYCLES−1: if P>0 or input_pulse=1, go to HIGH with cnt=0. Otherwise go to IDLE.
- Pending arithmetic in HIGH and GAP, using in=input_pulse and dec=1 only on the GAP→HIGH transition:
  - P_next = P + in − dec.
  - The increment saturates at 2**PEND_BITS−1.
  - On the GAP→HIGH transition with P=0 and in=1, the incoming pulse is consumed directly and P stays 0.
  - A pulse arriving when P is full and dec=0 is dropped.
- Simultaneous pulse and dequeue while P is full: P is unchanged and nothing is dropped.
- P is never decremented below 0. The dequeue happens only on the GAP→HIGH transition.

## Timing
- All outputs are registered and there are no combinational paths from input to output.
- Cycle convention: input_pulse high in cycle n (sampled at the edge ending cycle n) gives:
  - output_stretched=1 in cycles n+1 … n+HIGH_CYCLES;
  - output_stretched=0 in cycles n+HIGH_CYCLES+1 … n+HIGH_CYCLES+GAP_CYCLES.
- Latency from IDLE: 1 cycle.
- Back-to-back windows have a period of exactly HIGH_CYCLES+GAP_CYCLES cycles, with no IDLE cycle between them.
- busy=1 from cycle n+1 through the last GAP cycle. It drops in the first IDLE cycle.
- pending reflects an enqueue one cycle after the pulse, and a dequeue in the first cycle of the new window.
- A reset asserted in cycle r gives all outputs at their reset values in cycle r+1, including when reset lands mid-window or mid-gap.

## Configuration
- PULSE_STRETCHER_OVERFLOW_EN defined:
  - The overflow port exists.
  - overflow is set in the cycle after a pulse is dropped.
  - It stays set until reset.
- Undefined:
  - The port and its register are absent.
  - Dropped pulses are discarded silently.
  - All other behaviour is identical.

## Test plan
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_BITS=2, with reset released before cycle 5.
- Single pulse in cycle 10 -> output_stretched=1 in cycles 11–14 and 0 in 15–16; busy=0 from cycle 17; pending=0 throughout.
- Pulses in cycles 10, 12 and 13 -> high windows 11–14, 17–20 and 23–26; pending=1 in cycle 13, 2 in 14, 1 in 17 and 0 in 23; IDLE from cycle 29.
- input_pulse high in cycles 10–14 -> pending reaches 3 in cycle 14 and the cycle-14 pulse is dropped; exactly 4 windows, starting at cycles 11, 17, 23 and 29; overflow=1 from cycle 15 when the macro is defined.
- Pulse in cycle 10, then a pulse in cycle 16 (the last GAP cycle, with P=0) -> second window 17–20 with no IDLE cycle; pending stays 0.
- Pulse in cycle 10, pulse in cycle 12, reset high in cycle 13 together with a pulse -> in cycle 14 output_stretched=0, busy=0, pending=0 and overflow=0; no further window without a new pulse.
